// File: rtl/uart_cmd_decoder.sv
// Line-command decoder: collects UART bytes, executes ONn/OFn/TGn/STATUS on newline,
// and streams an ASCII reply over valid/ready. Define UART_CMD_CASE_FOLD_EN to accept lowercase.
module uart_cmd_decoder #(
    parameter int NUM_CH  = 8,
    parameter int MAX_LEN = 8
) (
    input  logic              i_Clock,
    input  logic              i_Rst,
    input  logic              i_RX_DV,
    input  logic [7:0]        i_RX_Byte,
    input  logic [7:0]        i_Sensor,
    output logic              o_TX_Valid,
    output logic [7:0]        o_TX_Byte,
    input  logic              i_TX_Ready,
    output logic [NUM_CH-1:0] o_LEDs,
    output logic              o_Cmd_Err
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    typedef enum logic [1:0] {COLLECT, EXEC, RESP} state_t;
    typedef enum logic [1:0] {REP_OK, REP_ER, REP_STATUS} reply_t;

    state_t           state;
    reply_t           reply_kind;
    logic [7:0]       buffer [MAX_LEN];
    logic [LEN_W-1:0] len;
    logic             ovf;
    logic             drop;
    logic [2:0]       resp_idx;
    logic [7:0]       sensor_q;

    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? 8'(8'h30 + n) : 8'(8'h37 + n);
    endfunction

    function automatic logic [7:0] reply_byte(input reply_t kind, input logic [2:0] idx,
                                              input logic [7:0] sensor, input logic [7:0] leds);
        logic [7:0] b;
        b = 8'h0A;
        case (kind)
            REP_OK:  if (idx == 3'd0) b = "O"; else if (idx == 3'd1) b = "K";
            REP_ER:  if (idx == 3'd0) b = "E"; else if (idx == 3'd1) b = "R";
            default: begin
                case (idx)
                    3'd0:    b = "S";
                    3'd1:    b = "=";
                    3'd2:    b = hex_char(sensor[7:4]);
                    3'd3:    b = hex_char(sensor[3:0]);
                    3'd4:    b = ",";
                    3'd5:    b = hex_char(leds[7:4]);
                    3'd6:    b = hex_char(leds[3:0]);
                    default: b = 8'h0A;
                endcase
            end
        endcase
        return b;
    endfunction

    logic [7:0] rx_char;
    logic [7:0] leds8;
    logic       collect_wr;
    logic [2:0] last_idx;

    always_comb begin
`ifdef UART_CMD_CASE_FOLD_EN
        rx_char = (i_RX_Byte >= 8'h61 && i_RX_Byte <= 8'h7A) ? (i_RX_Byte - 8'h20) : i_RX_Byte;
`else
        rx_char = i_RX_Byte;
`endif
        leds8 = '0;
        leds8[NUM_CH-1:0] = o_LEDs;
        collect_wr = (state == COLLECT) && i_RX_DV && (i_RX_Byte != 8'h0D)
                     && (i_RX_Byte != 8'h0A) && (len < LEN_W'(MAX_LEN));
        last_idx = (reply_kind == REP_STATUS) ? 3'd7 : 3'd2;
    end

    // Decode of the buffered line; only meaningful while state == EXEC.
    logic [NUM_CH-1:0] digit_mask;
    logic [NUM_CH-1:0] dec_leds;
    reply_t            dec_kind;
    logic              is_len3, is_on, is_of, is_tg, is_status;

    always_comb begin
        digit_mask = '0;
        for (int i = 0; i < NUM_CH; i++) digit_mask[i] = (buffer[2] == 8'(8'h31 + i));
        is_len3   = (len == LEN_W'(3));
        is_on     = is_len3 && buffer[0] == "O" && buffer[1] == "N";
        is_of     = is_len3 && buffer[0] == "O" && buffer[1] == "F";
        is_tg     = is_len3 && buffer[0] == "T" && buffer[1] == "G";
        is_status = (len == LEN_W'(6)) &&
                    ({buffer[0], buffer[1], buffer[2], buffer[3], buffer[4], buffer[5]} == "STATUS");
        dec_kind  = REP_ER;
        dec_leds  = o_LEDs;
        if (!ovf && !drop) begin
            if ((is_on || is_of || is_tg) && (|digit_mask)) begin
                dec_kind = REP_OK;
                if (is_on)      dec_leds = o_LEDs | digit_mask;
                else if (is_of) dec_leds = o_LEDs & ~digit_mask;
                else            dec_leds = o_LEDs ^ digit_mask;
            end else if (is_status) begin
                dec_kind = REP_STATUS;
            end
        end
    end

    // NOTE: the line buffer is plain storage gated by len, so it has no reset.
    always_ff @(posedge i_Clock) begin
        for (int i = 0; i < MAX_LEN; i++)
            if (collect_wr && len == LEN_W'(i)) buffer[i] <= rx_char;
    end

    always_ff @(posedge i_Clock) begin
        if (i_Rst) begin
            state      <= COLLECT;
            reply_kind <= REP_OK;
            len        <= '0;
            ovf        <= 1'b0;
            drop       <= 1'b0;
            resp_idx   <= '0;
            sensor_q   <= '0;
            o_LEDs     <= '0;
            o_TX_Valid <= 1'b0;
            o_TX_Byte  <= 8'h00;
            o_Cmd_Err  <= 1'b0;
        end else begin
            o_Cmd_Err <= 1'b0;
            case (state)
                COLLECT: begin
                    if (i_RX_DV && i_RX_Byte == 8'h0A) begin
                        if (len != '0) state <= EXEC;
                    end else if (i_RX_DV && i_RX_Byte != 8'h0D) begin
                        if (collect_wr) len <= len + 1'b1;
                        else            ovf <= 1'b1;
                    end
                end
                EXEC: begin
                    o_LEDs     <= dec_leds;
                    o_Cmd_Err  <= (dec_kind == REP_ER);
                    reply_kind <= dec_kind;
                    sensor_q   <= i_Sensor;
                    resp_idx   <= '0;
                    o_TX_Valid <= 1'b1;
                    o_TX_Byte  <= reply_byte(dec_kind, 3'd0, i_Sensor, leds8);
                    len        <= '0;
                    ovf        <= 1'b0;
                    drop       <= i_RX_DV;  // a byte landing here still poisons the next line
                    state      <= RESP;
                end
                default: begin
                    if (i_RX_DV) drop <= 1'b1;
                    if (o_TX_Valid && i_TX_Ready) begin
                        if (resp_idx == last_idx) begin
                            o_TX_Valid <= 1'b0;
                            state      <= COLLECT;
                        end else begin
                            resp_idx  <= resp_idx + 3'd1;
                            o_TX_Byte <= reply_byte(reply_kind, resp_idx + 3'd1, sensor_q, leds8);
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Bench for uart_cmd_decoder: table of command lines plus hand sequences for
// stalls, dropped bytes, handshake-edge timing and reset mid-reply.
module tb_uart_cmd_decoder;
    localparam logic [1:0] K_OK = 2'd0, K_ER = 2'd1, K_ST = 2'd2, K_NONE = 2'd3;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic [7:0] sensor;
    logic       tx_valid;
    logic [7:0] tx_byte;
    logic       tx_ready;
    logic [7:0] leds;
    logic       cmd_err;

    uart_cmd_decoder #(.NUM_CH(8), .MAX_LEN(8)) dut (
        .i_Clock   (clk),
        .i_Rst     (rst),
        .i_RX_DV   (rx_dv),
        .i_RX_Byte (rx_byte),
        .i_Sensor  (sensor),
        .o_TX_Valid(tx_valid),
        .o_TX_Byte (tx_byte),
        .i_TX_Ready(tx_ready),
        .o_LEDs    (leds),
        .o_Cmd_Err (cmd_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [95:0] line;
        logic [3:0]  nchar;
        logic [7:0]  sensor;
        logic [1:0]  kind;
        logic [7:0]  leds;
    } vec_t;

    int         n_checks = 0;
    int         n_pass   = 0;
    int         err_cnt  = 0;
    int         ready_mode = 0;  // 0 high, 1 toggle, 2 low
    logic [7:0] exp_q [$];
    logic [7:0] led_model;
    vec_t       vecs [14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] hex(input logic [3:0] n);
        return (n < 4'd10) ? 8'(8'h30 + n) : 8'(8'h41 + n - 4'd10);
    endfunction

    function automatic vec_t mk(input logic [95:0] line, input int n, input logic [7:0] s,
                                input logic [1:0] k, input logic [7:0] l);
        vec_t v;
        v.line = line; v.nchar = 4'(n); v.sensor = s; v.kind = k; v.leds = l;
        return v;
    endfunction

    task automatic expect_reply(input logic [1:0] kind, input logic [7:0] s, input logic [7:0] l);
        case (kind)
            K_OK: begin exp_q.push_back("O"); exp_q.push_back("K"); exp_q.push_back(8'h0A); end
            K_ER: begin exp_q.push_back("E"); exp_q.push_back("R"); exp_q.push_back(8'h0A); end
            K_ST: begin
                exp_q.push_back("S"); exp_q.push_back("=");
                exp_q.push_back(hex(s[7:4])); exp_q.push_back(hex(s[3:0]));
                exp_q.push_back(",");
                exp_q.push_back(hex(l[7:4])); exp_q.push_back(hex(l[3:0]));
                exp_q.push_back(8'h0A);
            end
            default: ;
        endcase
    endtask

    // Called and returns just after a rising edge.
    task automatic send_byte(input logic [7:0] b);
        rx_dv = 1'b1; rx_byte = b;
        @(posedge clk); #1;
        rx_dv = 1'b0;
    endtask

    task automatic send_line(input logic [95:0] line, input int n);
        for (int i = 0; i < n; i++) send_byte(line[8*(n-1-i) +: 8]);
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || tx_valid) && n < 400) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 400) begin
            n_checks++;
            $display("FAIL reply_timeout: %0d bytes still pending", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run_line(input logic [95:0] line, input int n, input logic [1:0] kind,
                            input logic [7:0] exp_leds, input string name);
        int e0 = err_cnt;
        expect_reply(kind, sensor, led_model);
        send_line(line, n);
        wait_idle();
        led_model = exp_leds;
        check({name, "_leds"}, leds, exp_leds);
        check({name, "_err"}, err_cnt - e0, (kind == K_ER) ? 1 : 0);
    endtask

    initial begin
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = ~tx_ready;
                default: tx_ready = 1'b0;
            endcase
        end
    end

    // Scoreboard monitor: pops on each handshake, checks stability while stalled.
    initial begin
        logic       hold = 1'b0;
        logic [7:0] held = 8'h00;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    check("tx_valid_held", tx_valid, 1'b1);
                    check("tx_byte_stable", tx_byte, held);
                end
                if (tx_valid && tx_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_tx: got %0h, expected no byte", tx_byte);
                    end else begin
                        check("tx_byte", tx_byte, exp_q.pop_front());
                    end
                end
                hold = tx_valid && !tx_ready;
                held = tx_byte;
                if (cmd_err) err_cnt++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e0;
        rst = 1'b1; rx_dv = 1'b0; rx_byte = 8'h00; sensor = 8'h00; tx_ready = 1'b1;
        led_model = 8'h00;

        vecs[0]  = mk("ON1\n",          4, 8'h00, K_OK,   8'h01);
        vecs[1]  = mk("ON2\n",          4, 8'h00, K_OK,   8'h03);
        vecs[2]  = mk("OF1\n",          4, 8'h00, K_OK,   8'h02);
        vecs[3]  = mk("TG8\n",          4, 8'h00, K_OK,   8'h82);
        vecs[4]  = mk("STATUS\r\n",     8, 8'h5A, K_ST,   8'h82);
        vecs[5]  = mk("ON9\n",          4, 8'h11, K_ER,   8'h82);
        vecs[6]  = mk("ON0\n",          4, 8'h00, K_ER,   8'h82);
        vecs[7]  = mk("ONXXXXXXXX\n",  11, 8'h00, K_ER,   8'h82);
        vecs[8]  = mk("\n",             1, 8'h00, K_NONE, 8'h82);
        vecs[9]  = mk("ON12\n",         5, 8'h00, K_ER,   8'h82);
        vecs[10] = mk("STATU\n",        6, 8'h00, K_ER,   8'h82);
        vecs[11] = mk("TG2\n",          4, 8'h00, K_OK,   8'h80);
        vecs[12] = mk("TG8\n",          4, 8'h00, K_OK,   8'h00);
        vecs[13] = mk("ON8\n",          4, 8'h00, K_OK,   8'h80);

        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_byte", tx_byte, 8'h00);
        check("rst_leds", leds, 8'h00);
        check("rst_cmd_err", cmd_err, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            sensor     = vecs[i].sensor;
            ready_mode = (vecs[i].kind == K_ST) ? 1 : 0;
            run_line(vecs[i].line, int'(vecs[i].nchar), vecs[i].kind, vecs[i].leds,
                     $sformatf("vec%0d", i));
        end
        ready_mode = 0;

        // Latency, and a byte sampled on the edge of the final handshake is dropped.
        e0 = err_cnt;
        expect_reply(K_OK, sensor, led_model);
        send_line("ON5\n", 4);
        check("lat_exec_valid", tx_valid, 1'b0);
        @(posedge clk); #1;
        check("lat_first_valid", tx_valid, 1'b1);
        check("lat_first_byte", tx_byte, "O");
        check("lat_leds", leds, 8'h90);
        @(posedge clk); @(posedge clk); #1;
        send_byte("X");
        wait_idle();
        run_line("ON5\n", 4, K_ER, 8'h90, "drop_edge");
        run_line("ON5\n", 4, K_OK, 8'h90, "after_drop");
        check("edge_seq_err", err_cnt - e0, 1);

        // A byte sampled the cycle after the final handshake is collected.
        expect_reply(K_OK, sensor, led_model);
        send_line("ON6\n", 4);
        repeat (4) @(posedge clk);
        #1;
        run_line("ON7\n", 4, K_OK, 8'hF0, "next_cycle");

        // Bytes arriving during a held-off reply are dropped and poison the next line.
        ready_mode = 2;
        expect_reply(K_OK, sensor, led_model);
        send_line("ON1\n", 4);
        repeat (3) @(posedge clk);
        #1;
        send_line("ON3\n", 4);
        check("held_leds", leds, 8'hF1);
        check("held_valid", tx_valid, 1'b1);
        check("held_byte", tx_byte, "O");
        ready_mode = 0;
        wait_idle();
        led_model = 8'hF1;
        run_line("ON4\n", 4, K_ER, 8'hF1, "poisoned");
        run_line("ON4\n", 4, K_OK, 8'hF9, "recovered");

        // Reset during a stalled STATUS reply aborts it.
        ready_mode = 2;
        sensor = 8'hC3;
        send_line("STATUS\n", 7);
        repeat (3) @(posedge clk);
        #1;
        check("st_stalled_valid", tx_valid, 1'b1);
        check("st_stalled_byte", tx_byte, "S");
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_valid", tx_valid, 1'b0);
        check("rst_mid_leds", leds, 8'h00);
        rst = 1'b0;
        ready_mode = 0;
        led_model = 8'h00;
        @(posedge clk); #1;
        check("rst_mid_quiet", tx_valid, 1'b0);

`ifdef UART_CMD_CASE_FOLD_EN
        run_line("on1\n", 4, K_OK, 8'h01, "lower_on1");
`else
        run_line("on1\n", 4, K_ER, 8'h00, "lower_on1");
`endif

        repeat (4) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
